adder_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one N-bit adder datapath among four requesters. Each requester presents an operand pair under a valid/ready handshake. The block grants one requester per cycle, registers the sum with its carry, and holds the tagged result until the downstream consumer accepts it. It sits between the operand sources and the shared adder result path, and is the only owner of the adder.

---
 rtl/adder_rr_arbiter.sv | 97 +++++++++
 tb/tb_adder_rr_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one N-bit adder among four valid/ready requesters.
// Optional macro ADDER_RR_ARB_SAT_EN clamps sums >= 2^N to {1'b0, {N{1'b1}}}.
module adder_rr_arbiter #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req_valid,
    input  logic [4*N-1:0] a_in,
    input  logic [4*N-1:0] b_in,
    output logic [3:0]     req_ready,
    output logic           res_valid,
    output logic [N:0]     res_data,
    output logic [1:0]     res_id,
    input  logic           res_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       r_state;
    logic [1:0]   r_ptr;
    logic         r_res_valid;
    logic [N:0]   r_res_data;
    logic [1:0]   r_res_id;

    logic [N-1:0] w_a [4];
    logic [N-1:0] w_b [4];
    logic         w_can_accept;
    logic         w_found;
    logic [1:0]   w_idx;
    logic [1:0]   w_cand;
    logic         w_fire;
    logic [N:0]   w_sum;
    logic [N:0]   w_sum_out;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            w_a[i] = a_in[i*N +: N];
            w_b[i] = b_in[i*N +: N];
        end
    end

    assign w_can_accept = (r_state == IDLE) | res_ready;

    // First valid requester in the order p, p+1, p+2, p+3 (mod 4).
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        w_cand  = r_ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign w_fire    = !rst && w_can_accept && w_found;
    assign req_ready = w_fire ? (4'b0001 << w_idx) : '0;

    assign w_sum = {1'b0, w_a[w_idx]} + {1'b0, w_b[w_idx]};

`ifdef ADDER_RR_ARB_SAT_EN
    assign w_sum_out = w_sum[N] ? {1'b0, {N{1'b1}}} : w_sum;
`else
    assign w_sum_out = w_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
        end else if (w_fire) begin
            // Grant also covers the consume-and-reload case in HOLD.
            r_state     <= HOLD;
            r_ptr       <= w_idx + 2'd1;
            r_res_valid <= 1'b1;
            r_res_data  <= w_sum_out;
            r_res_id    <= w_idx;
        end else if ((r_state == HOLD) && res_ready) begin
            r_state     <= IDLE;
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed self-checking bench for adder_rr_arbiter (N=8).
module tb_adder_rr_arbiter;

    localparam int unsigned N = 8;

    logic           clk;
    logic           rst;
    logic [3:0]     req_valid;
    logic [4*N-1:0] a_in;
    logic [4*N-1:0] b_in;
    logic [3:0]     req_ready;
    logic           res_valid;
    logic [N:0]     res_data;
    logic [1:0]     res_id;
    logic           res_ready;

    int unsigned n_checks;
    int unsigned n_fail;

    logic [N:0] sum_tbl [4];
    logic [N:0] carry_exp;

    adder_rr_arbiter #(.N(N)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .a_in      (a_in),
        .b_in      (b_in),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Registered outputs are sampled and inputs driven 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int unsigned i, input logic [N-1:0] a, input logic [N-1:0] b);
        a_in[i*N +: N] = a;
        b_in[i*N +: N] = b;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
`ifdef ADDER_RR_ARB_SAT_EN
        carry_exp = 9'h0FF;
`else
        carry_exp = 9'h100;
`endif
        sum_tbl[0] = 9'h011;
        sum_tbl[1] = 9'h022;
        sum_tbl[2] = 9'h033;
        sum_tbl[3] = 9'h044;

        // Reset held two cycles with everything requesting
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_req_ready", 32'(req_ready), 32'h0);
            check("rst_res_valid", 32'(res_valid), 32'h0);
            check("rst_res_data",  32'(res_data),  32'h0);
            check("rst_res_id",    32'(res_id),    32'h0);
        end
        rst = 1'b0;
        #1;
        check("first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        check("first_res_valid", 32'(res_valid), 32'h1);
        check("first_res_id",    32'(res_id),    32'h0);
        step();
        check("drain_res_valid", 32'(res_valid), 32'h0);

        // Single request from requester 2
        set_op(2, 8'h05, 8'h03);
        req_valid = 4'b0100;
        #1;
        check("single_req_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0000;
        check("single_res_valid", 32'(res_valid), 32'h1);
        check("single_res_data",  32'(res_data),  32'h008);
        check("single_res_id",    32'(res_id),    32'h2);
        #1;
        check("single_one_cycle", 32'(req_ready), 32'h0);
        step();

        // Carry out / saturation from requester 1
        set_op(1, 8'hFF, 8'h01);
        req_valid = 4'b0010;
        #1;
        check("carry_req_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0000;
        check("carry_res_data", 32'(res_data), 32'(carry_exp));
        check("carry_res_id",   32'(res_id),   32'h1);
        step();

        // Fresh pointer, then all four requesting with consumer always ready
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, 8'(8'h10 * (i + 1)), 8'(i + 1));
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_req_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            step();
            check("rr_res_valid", 32'(res_valid), 32'h1);
            check("rr_res_id",    32'(res_id),    32'(k % 4));
            check("rr_res_data",  32'(res_data),  32'(sum_tbl[k % 4]));
        end

        // Backpressure: hold result from requester 0 while requester 3 waits
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b0001;
        step();
        check("bp_setup_id", 32'(res_id), 32'h0);
        req_valid = 4'b1000;
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_req_ready", 32'(req_ready), 32'h0);
            step();
            check("bp_res_valid", 32'(res_valid), 32'h1);
            check("bp_res_id",    32'(res_id),    32'h0);
            check("bp_res_data",  32'(res_data),  32'h011);
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'h8);
        step();
        check("bp_res_id_after",   32'(res_id),   32'h3);
        check("bp_res_data_after", 32'(res_data), 32'h044);

        // Move pointer off zero (grant 1 -> p=2), then reset while holding
        req_valid = 4'b0010;
        step();
        check("mid_setup_id", 32'(res_id), 32'h1);
        req_valid = 4'b0000;
        res_ready = 1'b0;
        step();
        rst = 1'b1;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'h0);
        step();
        check("mid_rst_res_valid", 32'(res_valid), 32'h0);
        check("mid_rst_res_data",  32'(res_data),  32'h0);
        check("mid_rst_res_id",    32'(res_id),    32'h0);
        rst = 1'b0;
        #1;
        check("mid_rst_grant", 32'(req_ready), 32'h1);
        step();
        check("mid_rst_res_id",   32'(res_id),   32'h0);
        check("mid_rst_res_data2", 32'(res_data), 32'h011);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
